// File: rtl/dc_bsp_pkg.sv
// Board-support shared definitions: interrupt line allocation, ASP irq CSR word
// offsets and the aggregator delivery FSM state type.
package dc_bsp_pkg;

    localparam int BSP_NUM_INTERRUPT_LINES = 4;
    localparam int BSP_DMA_0_IRQ_BIT       = 0;
    localparam int BSP_KERNEL_IRQ_BIT      = 1;
    localparam int BSP_DMA_1_IRQ_BIT       = 2;

    localparam logic [2:0] ASP_IRQ_CSR_RAW     = 3'd0;
    localparam logic [2:0] ASP_IRQ_CSR_ENABLE  = 3'd1;
    localparam logic [2:0] ASP_IRQ_CSR_PENDING = 3'd2;
    localparam logic [2:0] ASP_IRQ_CSR_MODE    = 3'd3;
    localparam logic [2:0] ASP_IRQ_CSR_HOLDOFF = 3'd4;
    localparam logic [2:0] ASP_IRQ_CSR_COUNT   = 3'd5;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ASSERT,
        IRQ_HOLDOFF
    } asp_irq_state_e;

endpackage

// File: rtl/asp_irq_line.sv
// One interrupt pending cell: optional rising-edge detect, level/edge set,
// write-one-to-clear, with a set in the same cycle taking priority over clear.
module asp_irq_line #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic clr_i,
    output logic pending_o
);

    logic set;
    logic pending_q;
    logic pending_d;

    if (EDGE_MODE) begin : g_edge
        // History starts at 0 so a line already high at reset release counts as one edge.
        logic irq_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                irq_q <= 1'b0;
            end else begin
                irq_q <= irq_i;
            end
        end
        assign set = irq_i & ~irq_q;
    end else begin : g_level
        assign set = irq_i;
    end

    assign pending_d = set | (pending_q & ~clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/asp_irq_aggregator.sv
// ASP interrupt aggregator: per-line pending cells, AVMM CSR block and a
// req/ack host interrupt FSM with coalescing hold-off and delivery counter.
module asp_irq_aggregator
    import dc_bsp_pkg::*;
#(
    parameter int          NUM_IRQ_LINES  = BSP_NUM_INTERRUPT_LINES,
    parameter int          NUM_IRQ_USED   = BSP_DMA_1_IRQ_BIT + 1,
    parameter logic [31:0] EDGE_MODE_MASK = (32'd1 << BSP_DMA_0_IRQ_BIT) |
                                            (32'd1 << BSP_KERNEL_IRQ_BIT) |
                                            (32'd1 << BSP_DMA_1_IRQ_BIT),
    parameter logic [31:0] ENABLE_RESET   = 32'd1 << BSP_KERNEL_IRQ_BIT,
    parameter int          CSR_DATA_WIDTH = 64,
    parameter int          HOLDOFF_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_IRQ_LINES-1:0]      irq_in,
    input  logic [2:0]                    csr_address,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [CSR_DATA_WIDTH-1:0]     csr_writedata,
    input  logic [CSR_DATA_WIDTH/8-1:0]   csr_byteenable,
    output logic [CSR_DATA_WIDTH-1:0]     csr_readdata,
    output logic                          csr_readdatavalid,
    output logic                          csr_waitrequest,
    output logic                          irq_req,
    input  logic                          irq_ack
);

    localparam logic [63:0] USED_ALL = (64'd1 << NUM_IRQ_USED) - 64'd1;
    localparam logic [NUM_IRQ_LINES-1:0] USED_MASK = USED_ALL[NUM_IRQ_LINES-1:0];
    localparam logic [NUM_IRQ_LINES-1:0] MODE_VAL  = EDGE_MODE_MASK[NUM_IRQ_LINES-1:0] & USED_MASK;
    localparam logic [NUM_IRQ_LINES-1:0] EN_RST    = ENABLE_RESET[NUM_IRQ_LINES-1:0];
    localparam logic [31:0]              COUNT_MAX = '1;

    logic [CSR_DATA_WIDTH-1:0] wmask;
    logic                      wr_enable;
    logic                      wr_pending;
    logic                      wr_holdoff;
    logic [NUM_IRQ_LINES-1:0]  clr;
    logic [NUM_IRQ_LINES-1:0]  pending;
    logic [NUM_IRQ_LINES-1:0]  enable_q,  enable_d;
    logic [HOLDOFF_WIDTH-1:0]  holdoff_q, holdoff_d;
    logic [HOLDOFF_WIDTH-1:0]  hcnt_q,    hcnt_d;
    logic [31:0]               count_q,   count_d;
    asp_irq_state_e            state_q,   state_d;
    logic [CSR_DATA_WIDTH-1:0] readdata_q, readdata_d;
    logic                      rvalid_q;
    logic                      unused_bits;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < CSR_DATA_WIDTH / 8; b++) begin
            wmask[b*8 +: 8] = {8{csr_byteenable[b]}};
        end
    end

    assign wr_enable  = csr_write && (csr_address == ASP_IRQ_CSR_ENABLE);
    assign wr_pending = csr_write && (csr_address == ASP_IRQ_CSR_PENDING);
    assign wr_holdoff = csr_write && (csr_address == ASP_IRQ_CSR_HOLDOFF);

    assign clr = wr_pending ? (csr_writedata[NUM_IRQ_LINES-1:0] & wmask[NUM_IRQ_LINES-1:0]) : '0;

    for (genvar i = 0; i < NUM_IRQ_LINES; i++) begin : g_line
        if (i < NUM_IRQ_USED) begin : g_used
            asp_irq_line #(
                .EDGE_MODE (EDGE_MODE_MASK[i])
            ) u_line (
                .clk_i     (clk),
                .rst_i     (reset),
                .irq_i     (irq_in[i]),
                .clr_i     (clr[i]),
                .pending_o (pending[i])
            );
        end else begin : g_unused
            assign pending[i] = 1'b0;
        end
    end

    always_comb begin
        enable_d  = enable_q;
        holdoff_d = holdoff_q;
        if (wr_enable) begin
            enable_d = (enable_q & ~wmask[NUM_IRQ_LINES-1:0]) |
                       (csr_writedata[NUM_IRQ_LINES-1:0] & wmask[NUM_IRQ_LINES-1:0]);
        end
        if (wr_holdoff) begin
            holdoff_d = (holdoff_q & ~wmask[HOLDOFF_WIDTH-1:0]) |
                        (csr_writedata[HOLDOFF_WIDTH-1:0] & wmask[HOLDOFF_WIDTH-1:0]);
        end
    end

    always_comb begin
        readdata_d = '0;
        case (csr_address)
            ASP_IRQ_CSR_RAW:     readdata_d = CSR_DATA_WIDTH'(irq_in & USED_MASK);
            ASP_IRQ_CSR_ENABLE:  readdata_d = CSR_DATA_WIDTH'(enable_q & USED_MASK);
            ASP_IRQ_CSR_PENDING: readdata_d = CSR_DATA_WIDTH'(pending);
            ASP_IRQ_CSR_MODE:    readdata_d = CSR_DATA_WIDTH'(MODE_VAL);
            ASP_IRQ_CSR_HOLDOFF: readdata_d = CSR_DATA_WIDTH'(holdoff_q);
            ASP_IRQ_CSR_COUNT:   readdata_d = CSR_DATA_WIDTH'(count_q);
            default:             readdata_d = '0;
        endcase
    end

    // Once asserted, the request is held until the host acks, whatever happens to PENDING/ENABLE.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        count_d = count_q;
        case (state_q)
            IRQ_IDLE: begin
                if (|(pending & enable_q)) begin
                    state_d = IRQ_ASSERT;
                end
            end
            IRQ_ASSERT: begin
                if (irq_ack) begin
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;
                    hcnt_d  = holdoff_q;
                    state_d = IRQ_HOLDOFF;
                end
            end
            IRQ_HOLDOFF: begin
                if (hcnt_q == '0) begin
                    state_d = IRQ_IDLE;
                end else begin
                    hcnt_d = hcnt_q - HOLDOFF_WIDTH'(1);
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q   <= EN_RST;
            holdoff_q  <= '0;
            hcnt_q     <= '0;
            count_q    <= '0;
            state_q    <= IRQ_IDLE;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            holdoff_q  <= holdoff_d;
            hcnt_q     <= hcnt_d;
            count_q    <= count_d;
            state_q    <= state_d;
            readdata_q <= csr_read ? readdata_d : '0;
            rvalid_q   <= csr_read;
        end
    end

    assign csr_readdata      = readdata_q;
    assign csr_readdatavalid = rvalid_q;
    assign csr_waitrequest   = 1'b0;
    assign irq_req           = (state_q == IRQ_ASSERT);

    assign unused_bits = ^{csr_writedata, wmask, clr};

endmodule

// File: tb/tb_asp_irq_aggregator.sv
// Bench for asp_irq_aggregator: directed scenarios plus random traffic, all
// checked cycle by cycle against a rule-level model of pending/delivery timing.
module tb_asp_irq_aggregator;

  localparam logic [3:0] EDGE_M = 4'b0101;  // line 1 level sensitive
  localparam logic [3:0] USED_M = 4'b0111;
  localparam logic [3:0] EN_RST = 4'b0010;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_in = '0;
  logic [2:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [63:0] csr_writedata = '0;
  logic [7:0]  csr_byteenable = '0;
  logic [63:0] csr_readdata;
  logic        csr_readdatavalid;
  logic        csr_waitrequest;
  logic        irq_req;
  logic        irq_ack = 1'b0;

  always #5 clk = ~clk;

  asp_irq_aggregator #(
    .NUM_IRQ_LINES  (4),
    .NUM_IRQ_USED   (3),
    .EDGE_MODE_MASK (32'b101),
    .ENABLE_RESET   (32'b010),
    .CSR_DATA_WIDTH (64),
    .HOLDOFF_WIDTH  (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .irq_in            (irq_in),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_byteenable    (csr_byteenable),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .csr_waitrequest   (csr_waitrequest),
    .irq_req           (irq_req),
    .irq_ack           (irq_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [3:0]  m_pend, m_en, m_prev;
  logic [15:0] m_hold;
  logic [31:0] m_count;
  logic        m_req;
  int          m_idle_at;
  int          cyc_n;
  logic [3:0]  cur_irq = '0;
  logic [63:0] last_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [2:0] a, input logic [3:0] raw);
    case (a)
      3'd0:    return {60'd0, raw & USED_M};
      3'd1:    return {60'd0, m_en & USED_M};
      3'd2:    return {60'd0, m_pend};
      3'd3:    return {60'd0, EDGE_M & USED_M};
      3'd4:    return {48'd0, m_hold};
      3'd5:    return {32'd0, m_count};
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = EN_RST; m_prev = '0; m_hold = '0; m_count = '0;
    m_req = 1'b0; m_idle_at = 0; cyc_n = 0;
  endtask

  // driver: one clock cycle of stimulus, model advance, and output checks
  task automatic step(input logic [3:0] irq, input logic wr, input logic [2:0] a,
                      input logic [63:0] d, input logic [7:0] be, input logic rd,
                      input logic ack);
    logic [63:0] bm;
    logic [63:0] exp_rd;
    logic [3:0]  set;
    logic [3:0]  clr;
    irq_in = irq; csr_write = wr; csr_address = a; csr_writedata = d;
    csr_byteenable = be; csr_read = rd; irq_ack = ack;
    @(posedge clk);
    for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{be[b]}};
    exp_rd = model_rd(a, irq);
    set = '0;
    for (int i = 0; i < 4; i++)
      if (USED_M[i]) set[i] = EDGE_M[i] ? (irq[i] & ~m_prev[i]) : irq[i];
    clr = (wr && a == 3'd2) ? (d[3:0] & bm[3:0]) : 4'd0;
    // Delivery rule: after an ack, earliest new request is holdoff+2 cycles later.
    if (m_req) begin
      if (ack) begin
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        m_req = 1'b0;
        m_idle_at = cyc_n + int'(m_hold) + 2;
      end
    end else if (cyc_n >= m_idle_at && (m_pend & m_en) != 4'd0) begin
      m_req = 1'b1;
    end
    m_pend = set | (m_pend & ~clr);
    if (wr && a == 3'd1) m_en = (m_en & ~bm[3:0]) | (d[3:0] & bm[3:0]);
    if (wr && a == 3'd4) m_hold = (m_hold & ~bm[15:0]) | (d[15:0] & bm[15:0]);
    m_prev = irq;
    cyc_n++;
    #1;
    check("rvalid", {63'd0, csr_readdatavalid}, {63'd0, rd});
    if (rd) begin
      check("rdata", csr_readdata, exp_rd);
      last_rd = csr_readdata;
    end
    check("irq_req", {63'd0, irq_req}, {63'd0, m_req});
    check("waitreq", {63'd0, csr_waitrequest}, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(cur_irq, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr_csr(input logic [2:0] a, input logic [63:0] d);
    step(cur_irq, 1'b1, a, d, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic rd_csr(input logic [2:0] a);
    step(cur_irq, 1'b0, a, 64'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic ack1();
    step(cur_irq, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (!irq_req && n < budget) begin
      idle(1);
      n++;
    end
    check("wait_req", {63'd0, irq_req}, 64'd1);
  endtask

  task automatic drain();
    cur_irq = '0;
    wr_csr(3'd1, 64'd0);
    wr_csr(3'd2, 64'hF);
    ack1();
    while (cyc_n < m_idle_at) idle(1);
    idle(2);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cur_irq = '0;
    irq_in = '0; csr_write = 1'b0; csr_read = 1'b0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_csrs(input string tag);
    logic [63:0] exp_tab [8];
    exp_tab = '{64'd0, 64'd2, 64'd0, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0};
    for (int a = 0; a < 8; a++) begin
      rd_csr(3'(a));
      check(tag, last_rd, exp_tab[a]);
    end
    check({tag, "_req"}, {63'd0, irq_req}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic        r_wr, r_rd, r_ack;
    logic [2:0]  r_a;
    logic [63:0] r_d;
    logic [7:0]  r_be;

    reset_dut();
    check_reset_csrs("rst_csr");

    // edge line 0
    wr_csr(3'd1, 64'h1);
    cur_irq = 4'b0001; idle(1); cur_irq = '0;
    rd_csr(3'd2);
    check("edge_pend", last_rd, 64'h1);
    check("edge_req", {63'd0, irq_req}, 64'd1);
    ack1();
    check("edge_ack_req", {63'd0, irq_req}, 64'd0);
    rd_csr(3'd5);
    check("edge_count", last_rd, 64'd1);
    drain();

    // level line 1
    wr_csr(3'd1, 64'h2);
    cur_irq = 4'b0010; idle(3);
    wr_csr(3'd2, 64'h2);
    rd_csr(3'd2);
    check("lvl_hold", last_rd, 64'h2);
    cur_irq = '0;
    wr_csr(3'd2, 64'h2);
    rd_csr(3'd2);
    check("lvl_clr", last_rd, 64'h0);
    drain();

    // set wins over same-cycle clear
    wr_csr(3'd1, 64'h4);
    step(4'b0100, 1'b1, 3'd2, 64'h4, 8'hFF, 1'b0, 1'b0);
    rd_csr(3'd2);
    check("setwin_pend", last_rd & 64'h4, 64'h4);
    wait_req(4, n);
    drain();

    // masked delivery
    cur_irq = 4'b0001; idle(1); cur_irq = '0;
    idle(4);
    check("mask_noreq", {63'd0, irq_req}, 64'd0);
    rd_csr(3'd2);
    check("mask_pend", last_rd, 64'h1);
    wr_csr(3'd1, 64'h1);
    wait_req(2, n);
    drain();

    // coalescing hold-off, with a mid-hold-off rewrite of HOLDOFF
    wr_csr(3'd4, 64'd100);
    wr_csr(3'd1, 64'h2);
    cur_irq = 4'b0010;
    wait_req(5, n);
    ack1();
    n = 0;
    while (!irq_req && n < 300) begin
      if (n == 10) wr_csr(3'd4, 64'd0);
      else idle(1);
      n++;
    end
    check("holdoff100", 64'(n), 64'd102);
    ack1();
    n = 0;
    while (!irq_req && n < 300) begin
      idle(1);
      n++;
    end
    check("holdoff0", 64'(n), 64'd2);
    drain();

    // unused line 3
    wr_csr(3'd1, 64'hF);
    cur_irq = 4'b1000; idle(1); cur_irq = '0;
    rd_csr(3'd2);
    check("unused_pend", last_rd, 64'h0);
    idle(3);
    check("unused_noreq", {63'd0, irq_req}, 64'd0);

    // async reset while asserting
    wr_csr(3'd1, 64'h1);
    cur_irq = 4'b0001; idle(1); cur_irq = '0;
    wait_req(4, n);
    #2 reset = 1'b1;
    #1 check("rst_drop", {63'd0, irq_req}, 64'd0);
    model_reset();
    irq_in = '0; csr_write = 1'b0; csr_read = 1'b0; irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_csrs("rst2_csr");

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) cur_irq[b] = ~cur_irq[b];
      r_wr  = ($urandom_range(0, 3) == 0);
      r_a   = 3'($urandom_range(0, 7));
      r_d   = {$urandom, $urandom};
      if (r_a == 3'd4) r_d = 64'($urandom_range(0, 12));
      r_be  = 8'($urandom_range(0, 255));
      r_rd  = 1'($urandom_range(0, 1));
      r_ack = ($urandom_range(0, 3) == 0);
      step(cur_irq, r_wr, r_a, r_d, r_be, r_rd, r_ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
